// File: rtl/ant_scan_peak.sv
// Antenna sweep controller. Steps the antenna select through every antenna and
// tracks the peak returned power. When the sweep ends it parks the select on the winner.
module ant_scan_peak #(
  parameter int               NUM_ANT = 16,
  parameter int               POW_W   = 32,
  parameter logic [POW_W-1:0] THRESH  = {POW_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POW_W-1:0] ant_pow,
  output logic [3:0]       ant_posinfo,
  output logic             busy,
  output logic             done,
  output logic [3:0]       peak_idx,
  output logic [POW_W-1:0] peak_pow,
  output logic             no_sig
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(NUM_ANT - 2);

  state_t           state, state_nxt;
  logic             drain_cnt;
  logic [1:0]       cap_vld;
  logic [3:0]       cap_idx0, cap_idx1;
  logic [POW_W-1:0] run_max;
  logic [3:0]       run_idx;
  logic             have_max;

  logic [3:0]       pos_nxt;
  logic             busy_nxt, done_nxt, load_res, load_vld, accept;
  logic             take;
  logic [POW_W-1:0] cmp_pow;
  logic [3:0]       cmp_idx;

  // State register; drain_cnt marks the second DRAIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SWEEP;
        else       state_nxt = IDLE;
      end
      SWEEP: begin
        if (ant_posinfo == PRE_LAST) state_nxt = DRAIN;
        else                         state_nxt = SWEEP;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = IDLE;
        else           state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/next-value decode for the registered controls.
  always_comb begin
    pos_nxt  = ant_posinfo;
    busy_nxt = busy;
    done_nxt = 1'b0;
    load_res = 1'b0;
    load_vld = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pos_nxt  = 4'd0;
          busy_nxt = 1'b1;
          load_vld = 1'b1;
          accept   = 1'b1;
        end else begin
          pos_nxt  = ant_posinfo;
        end
      end
      SWEEP: begin
        pos_nxt  = ant_posinfo + 4'd1;
        load_vld = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt) begin
          pos_nxt  = cmp_idx;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          load_res = 1'b1;
        end else begin
          pos_nxt  = ant_posinfo;
        end
      end
      default: begin
        pos_nxt  = 4'd0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Running-max candidate including the sample arriving this cycle.
  always_comb begin
    take    = cap_vld[1] && (!have_max || (ant_pow > run_max));
    cmp_pow = run_max;
    cmp_idx = run_idx;
    if (take) begin
      cmp_pow = ant_pow;
      cmp_idx = cap_idx1;
    end else begin
      cmp_pow = run_max;
      cmp_idx = run_idx;
    end
  end

  // Registered outputs, capture pipeline and running max.
  always_ff @(posedge clk) begin
    if (rst) begin
      ant_posinfo <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      peak_idx    <= 4'd0;
      peak_pow    <= {POW_W{1'b0}};
      no_sig      <= 1'b0;
      cap_vld     <= 2'b00;
      cap_idx0    <= 4'd0;
      cap_idx1    <= 4'd0;
      run_max     <= {POW_W{1'b0}};
      run_idx     <= 4'd0;
      have_max    <= 1'b0;
    end else begin
      ant_posinfo <= pos_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      // Tag each select load so the sample two edges later knows its antenna.
      cap_vld     <= {cap_vld[0], load_vld};
      cap_idx0    <= pos_nxt;
      cap_idx1    <= cap_idx0;
      if (accept) begin
        have_max <= 1'b0;
      end else if (cap_vld[1]) begin
        have_max <= 1'b1;
        run_max  <= cmp_pow;
        run_idx  <= cmp_idx;
      end
      if (load_res) begin
        peak_idx <= cmp_idx;
        peak_pow <= cmp_pow;
        no_sig   <= (cmp_pow <= THRESH);
      end
    end
  end

endmodule

// File: tb/tb_ant_scan_peak.sv
// Directed bench for ant_scan_peak with a registered 16:1 power selector model.
module tb_ant_scan_peak;

  logic        clk = 1'b0;
  logic        rst, start, start_b;
  logic [31:0] pow_tab [16];
  logic [31:0] pow_b   [4];
  logic [31:0] sel_pow, sel_pow_b;
  logic [3:0]  ant_posinfo, peak_idx, ant_posinfo_b, peak_idx_b;
  logic        busy, done, no_sig, busy_b, done_b, no_sig_b;
  logic [31:0] peak_pow, peak_pow_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ant_scan_peak dut (
    .clk(clk), .rst(rst), .start(start), .ant_pow(sel_pow),
    .ant_posinfo(ant_posinfo), .busy(busy), .done(done),
    .peak_idx(peak_idx), .peak_pow(peak_pow), .no_sig(no_sig)
  );

  ant_scan_peak #(.NUM_ANT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ant_pow(sel_pow_b),
    .ant_posinfo(ant_posinfo_b), .busy(busy_b), .done(done_b),
    .peak_idx(peak_idx_b), .peak_pow(peak_pow_b), .no_sig(no_sig_b)
  );

  always @(posedge clk) begin
    sel_pow   <= pow_tab[ant_posinfo];
    sel_pow_b <= pow_b[ant_posinfo_b[1:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start; return at the negedge of the done cycle (k counted from the start edge).
  task automatic run_sweep(output int done_at, output int busy_cnt);
    done_at  = -1;
    busy_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"},  64'(ant_posinfo), 64'd0);
    chk({tag, "_busy"}, 64'(busy),        64'd0);
    chk({tag, "_done"}, 64'(done),        64'd0);
    chk({tag, "_idx"},  64'(peak_idx),    64'd0);
    chk({tag, "_pow"},  64'(peak_pow),    64'd0);
    chk({tag, "_nsig"}, 64'(no_sig),      64'd0);
  endtask

  initial begin
    int d, b, k;
    logic [3:0] seq [6];
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'd0;
    for (int i = 0; i < 4; i++)  pow_b[i]   = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Ascending ramp: last antenna wins.
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'(100 * (i + 1));
    run_sweep(d, b);
    chk("ramp_done_at", 64'(d), 64'd17);
    chk("ramp_busy",    64'(b), 64'd17);
    chk("ramp_idx",     64'(peak_idx), 64'd15);
    chk("ramp_pow",     64'(peak_pow), 64'd1600);
    chk("ramp_nsig",    64'(no_sig), 64'd0);
    chk("ramp_park",    64'(ant_posinfo), 64'd15);
    @(negedge clk);
    chk("ramp_done_pulse", 64'(done), 64'd0);
    chk("ramp_park_hold",  64'(ant_posinfo), 64'd15);

    // MSB-set tie: unsigned compare, lowest index kept.
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'd50;
    pow_tab[3] = 32'h8000_0000;
    pow_tab[9] = 32'h8000_0000;
    run_sweep(d, b);
    chk("tie_idx",  64'(peak_idx), 64'd3);
    chk("tie_pow",  64'(peak_pow), 64'h8000_0000);
    chk("tie_park", 64'(ant_posinfo), 64'd3);

    // All zero: no signal at THRESH=0.
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'd0;
    run_sweep(d, b);
    chk("zero_idx",  64'(peak_idx), 64'd0);
    chk("zero_pow",  64'(peak_pow), 64'd0);
    chk("zero_nsig", 64'(no_sig), 64'd1);
    chk("zero_park", 64'(ant_posinfo), 64'd0);

    // Start while busy dropped; start during done accepted.
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'(i);
    pow_tab[12] = 32'd500;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 5;
    chk("ovl_busy_mid", 64'(busy), 64'd1);
    chk("ovl_pow_mid",  64'(peak_pow), 64'd0);
    chk("ovl_nsig_mid", 64'(no_sig), 64'd1);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ovl_done1_at", 64'(k), 64'd17);
    chk("ovl_idx1", 64'(peak_idx), 64'd12);
    chk("ovl_pow1", 64'(peak_pow), 64'd500);
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'd1;
    pow_tab[6] = 32'd700;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ovl_busy2", 64'(busy), 64'd1);
    k = 0;
    repeat (8) @(negedge clk);
    k = 8;
    chk("ovl_hold_idx", 64'(peak_idx), 64'd12);
    chk("ovl_hold_pow", 64'(peak_pow), 64'd500);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ovl_done2_at", 64'(k), 64'd17);
    chk("ovl_idx2", 64'(peak_idx), 64'd6);
    chk("ovl_pow2", 64'(peak_pow), 64'd700);
    repeat (5) @(negedge clk);
    chk("ovl_no_queue_busy", 64'(busy), 64'd0);
    chk("ovl_no_queue_park", 64'(ant_posinfo), 64'd6);

    // Reset mid-sweep, then a single-peak sweep.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) pow_tab[i] = 32'd5;
    pow_tab[7] = 32'd999;
    run_sweep(d, b);
    chk("rst_sw_done_at", 64'(d), 64'd17);
    chk("rst_sw_idx", 64'(peak_idx), 64'd7);
    chk("rst_sw_pow", 64'(peak_pow), 64'd999);
    chk("rst_sw_park", 64'(ant_posinfo), 64'd7);

    // Four-antenna instance: select sequence and early done.
    pow_b[0] = 32'd10; pow_b[1] = 32'd40; pow_b[2] = 32'd20; pow_b[3] = 32'd30;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    d = -1;
    for (int j = 0; j < 20; j++) begin
      if (j < 6) seq[j] = ant_posinfo_b;
      if (done_b) begin
        d = j;
        break;
      end
      @(negedge clk);
    end
    chk("b_done_at", 64'(d), 64'd5);
    chk("b_seq0", 64'(seq[0]), 64'd0);
    chk("b_seq1", 64'(seq[1]), 64'd1);
    chk("b_seq2", 64'(seq[2]), 64'd2);
    chk("b_seq3", 64'(seq[3]), 64'd3);
    chk("b_park", 64'(ant_posinfo_b), 64'd1);
    chk("b_idx",  64'(peak_idx_b), 64'd1);
    chk("b_pow",  64'(peak_pow_b), 64'd40);
    chk("b_nsig", 64'(no_sig_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
